// File: rtl/bt656cap_colorspace_if.sv
`default_nettype none
// ============================================================================
// Module      : bt656cap_colorspace_if
// Description : Decoder-side YCbCr word input and consumer-side RGB565 FIFO
//               output of the BT.656 colour-space converter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bt656cap_colorspace_if;
  logic        p_stb;
  logic        p_field;
  logic [31:0] p_ycc;
  logic        v_stb;
  logic        v_ack;
  logic        v_field;
  logic [31:0] v_rgb565;

  modport master (
    output p_stb, p_field, p_ycc, v_ack,
    input  v_stb, v_field, v_rgb565
  );

  modport slave (
    input  p_stb, p_field, p_ycc, v_ack,
    output v_stb, v_field, v_rgb565
  );
endinterface
`default_nettype wire

// File: rtl/bt656cap_colorspace.sv
`default_nettype none
// ============================================================================
// Module      : bt656cap_colorspace
// Description : 3-stage YCbCr 4:2:2 -> RGB565 converter feeding a FWFT FIFO.
//               Define BT656CAP_DROPCNT_EN to enable the dropped-word counter.
// Revision    : 1.0 - initial release
// ============================================================================
module bt656cap_colorspace #(
  parameter int fifo_depth = 2
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  bt656cap_colorspace_if.slave         bus,
  output logic                         overflow,
  output logic [15:0]                  drop_count,
  input  logic                         drop_clr
);

  localparam int C_ENTRIES = 1 << fifo_depth;

  function automatic logic [7:0] sat8(input logic signed [19:0] v);
    logic signed [19:0] s;
    s = v >>> 8;
    if (s < 20'sd0)        sat8 = 8'd0;
    else if (s > 20'sd255) sat8 = 8'hFF;
    else                   sat8 = s[7:0];
  endfunction

  function automatic logic [15:0] pack565(input logic signed [19:0] r,
                                          input logic signed [19:0] g,
                                          input logic signed [19:0] b);
    logic [7:0] r8, g8, b8;
    r8 = sat8(r);
    g8 = sat8(g);
    b8 = sat8(b);
    pack565 = ({8'd0, r8 & 8'hF8} << 8) | ({8'd0, g8 & 8'hFC} << 3) | ({8'd0, b8} >> 3);
  endfunction

  // Offset-removed components, widened so every product fits without overflow
  logic signed [19:0] w_ys0, w_ys1, w_cbs, w_crs;
  assign w_cbs = $signed({12'd0, bus.p_ycc[31:24]}) - 20'sd128;
  assign w_ys0 = $signed({12'd0, bus.p_ycc[23:16]}) - 20'sd16;
  assign w_crs = $signed({12'd0, bus.p_ycc[15:8]})  - 20'sd128;
  assign w_ys1 = $signed({12'd0, bus.p_ycc[7:0]})   - 20'sd16;

  logic               r_s1_valid, r_s1_field;
  logic signed [19:0] r_m_y0, r_m_y1, r_m_rcr, r_m_gcr, r_m_gcb, r_m_bcb;
  logic               r_s2_valid, r_s2_field;
  logic signed [19:0] r_r0, r_g0, r_b0, r_r1, r_g1, r_b1;
  logic               r_s3_valid, r_s3_field;
  logic [31:0]        r_s3_data;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else begin
      r_s1_valid <= bus.p_stb;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
    end
    r_s1_field <= bus.p_field;
    r_m_y0     <= w_ys0 * 20'sd298;
    r_m_y1     <= w_ys1 * 20'sd298;
    r_m_rcr    <= w_crs * 20'sd409;
    r_m_gcr    <= w_crs * 20'sd208;
    r_m_gcb    <= w_cbs * 20'sd100;
    r_m_bcb    <= w_cbs * 20'sd516;
    r_s2_field <= r_s1_field;
    r_r0       <= r_m_y0 + r_m_rcr + 20'sd128;
    r_g0       <= r_m_y0 - r_m_gcr - r_m_gcb + 20'sd128;
    r_b0       <= r_m_y0 + r_m_bcb + 20'sd128;
    r_r1       <= r_m_y1 + r_m_rcr + 20'sd128;
    r_g1       <= r_m_y1 - r_m_gcr - r_m_gcb + 20'sd128;
    r_b1       <= r_m_y1 + r_m_bcb + 20'sd128;
    r_s3_field <= r_s2_field;
    r_s3_data  <= {pack565(r_r0, r_g0, r_b0), pack565(r_r1, r_g1, r_b1)};
  end

  logic [32:0]           r_mem [C_ENTRIES];
  logic [fifo_depth-1:0] r_wr_ptr, r_rd_ptr;
  logic [fifo_depth:0]   r_count;
  logic [32:0]           r_hold;
  logic [32:0]           w_head;
  logic                  w_full, w_rd, w_wr, w_drop;

  assign w_full = (r_count == (fifo_depth + 1)'(C_ENTRIES));
  assign w_rd   = bus.v_stb & bus.v_ack;
  // A full FIFO still takes a write when the head leaves in the same cycle
  assign w_wr   = r_s3_valid & (~w_full | w_rd);
  assign w_drop = r_s3_valid & w_full & ~w_rd;
  assign w_head = r_mem[r_rd_ptr];

  assign overflow     = w_drop & ~sys_rst;
  assign bus.v_stb    = (r_count != '0);
  assign bus.v_rgb565 = bus.v_stb ? w_head[31:0] : r_hold[31:0];
  assign bus.v_field  = bus.v_stb ? w_head[32]   : r_hold[32];

  always_ff @(posedge sys_clk) begin
    if (w_wr && !sys_rst) begin
      r_mem[r_wr_ptr] <= {r_s3_field, r_s3_data};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_hold   <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_rd) r_count <= r_count - 1'b1;
      // Keeps the last presented word on the outputs once the FIFO drains
      if (bus.v_stb) r_hold <= w_head;
    end
  end

`ifdef BT656CAP_DROPCNT_EN
  logic [15:0] r_drop_count;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_drop_count <= '0;
    end else if (drop_clr) begin
      r_drop_count <= w_drop ? 16'd1 : 16'd0;
    end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end
  assign drop_count = r_drop_count;
`else
  logic w_unused_drop_clr;
  assign w_unused_drop_clr = drop_clr;
  assign drop_count        = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bt656cap_colorspace.sv
`default_nettype none
// ============================================================================
// Module      : tb_bt656cap_colorspace
// Description : Directed self-checking bench for bt656cap_colorspace.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bt656cap_colorspace;

  logic        sys_clk  = 1'b0;
  logic        sys_rst  = 1'b1;
  logic        drop_clr = 1'b0;
  logic        overflow;
  logic [15:0] drop_count;

  bt656cap_colorspace_if bus();

  bt656cap_colorspace #(.fifo_depth(2)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .bus        (bus),
    .overflow   (overflow),
    .drop_count (drop_count),
    .drop_clr   (drop_clr)
  );

  always #5 sys_clk = ~sys_clk;

`ifdef BT656CAP_DROPCNT_EN
  localparam int C_DROP_ON = 1;
`else
  localparam int C_DROP_ON = 0;
`endif

  // Hand-computed conversions
  logic [31:0] c_in  [5] = '{32'h80EB80EB, 32'h80108010, 32'h5A51F051, 32'h80EB8010, 32'h5A51F0EB};
  logic [31:0] c_exp [5] = '{32'hFFFFFFFF, 32'h00000000, 32'hF800F800, 32'hFFFF0000, 32'hF800FD96};

  int checks = 0;
  int errors = 0;
  int stale  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic issue_all();
    for (int i = 0; i < 5; i++) begin
      bus.p_stb   = 1'b1;
      bus.p_ycc   = c_in[i];
      bus.p_field = i[0];
      tick();
    end
    bus.p_stb = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bus.p_stb   = 1'b0;
    bus.p_field = 1'b0;
    bus.p_ycc   = '0;
    bus.v_ack   = 1'b0;
    tick();
    tick();
    check_eq("rst_v_stb",    bus.v_stb,    0);
    check_eq("rst_v_rgb",    bus.v_rgb565, 0);
    check_eq("rst_v_field",  bus.v_field,  0);
    check_eq("rst_overflow", overflow,     0);
    check_eq("rst_drop_cnt", drop_count,   0);
    sys_rst = 1'b0;

    // Latency: white word, v_stb in the 4th cycle after p_stb
    bus.v_ack   = 1'b1;
    bus.p_stb   = 1'b1;
    bus.p_ycc   = c_in[0];
    bus.p_field = 1'b0;
    tick();
    bus.p_stb = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check_eq("lat_early_v_stb", bus.v_stb, 0);
      tick();
    end
    check_eq("lat_v_stb", bus.v_stb,    1);
    check_eq("lat_white", bus.v_rgb565, c_exp[0]);
    tick();
    check_eq("lat_drained", bus.v_stb,    0);
    check_eq("lat_held",    bus.v_rgb565, c_exp[0]);

    // Back-to-back stream with toggling field
    for (int i = 1; i < 5; i++) begin
      bus.p_stb   = 1'b1;
      bus.p_ycc   = c_in[i];
      bus.p_field = i[0];
      tick();
    end
    bus.p_stb = 1'b0;
    for (int j = 1; j < 5; j++) begin
      check_eq("stream_v_stb", bus.v_stb,    1);
      check_eq("stream_rgb",   bus.v_rgb565, c_exp[j]);
      check_eq("stream_field", bus.v_field,  j[0]);
      tick();
    end
    check_eq("stream_empty", bus.v_stb, 0);

    // Overflow: 5 words into a 4-entry FIFO with no consumer
    bus.v_ack = 1'b0;
    issue_all();
    tick();
    tick();
    check_eq("ovf_pulse", overflow, 1);
    tick();
    check_eq("ovf_pulse_end", overflow,   0);
    check_eq("ovf_drop_cnt",  drop_count, C_DROP_ON);
    check_eq("ovf_v_stb",     bus.v_stb,  1);
    bus.v_ack = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check_eq("ovf_rgb",   bus.v_rgb565, c_exp[j]);
      check_eq("ovf_field", bus.v_field,  j[0]);
      tick();
    end
    check_eq("ovf_empty", bus.v_stb, 0);
    bus.v_ack = 1'b0;

    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    check_eq("drop_clr", drop_count, 0);

    // Full FIFO with read and write in the same cycle
    issue_all();
    tick();
    tick();
    bus.v_ack = 1'b1;
    #1;
    check_eq("full_rw_no_ovf", overflow,     0);
    check_eq("full_rw_head",   bus.v_rgb565, c_exp[0]);
    tick();
    bus.v_ack = 1'b0;
    check_eq("full_rw_v_stb",    bus.v_stb,  1);
    check_eq("full_rw_drop_cnt", drop_count, 0);
    bus.v_ack = 1'b1;
    for (int j = 1; j < 5; j++) begin
      check_eq("full_rw_rgb",   bus.v_rgb565, c_exp[j]);
      check_eq("full_rw_field", bus.v_field,  j[0]);
      tick();
    end
    check_eq("full_rw_empty", bus.v_stb, 0);
    bus.v_ack = 1'b0;

    // Reset with 3 words stored and 2 still in the pipeline
    issue_all();
    tick();
    check_eq("prerst_v_stb", bus.v_stb, 1);
    sys_rst     = 1'b1;
    bus.p_stb   = 1'b1;
    bus.p_ycc   = c_in[0];
    tick();
    sys_rst   = 1'b0;
    bus.p_stb = 1'b0;
    check_eq("midrst_v_stb",  bus.v_stb,    0);
    check_eq("midrst_rgb",    bus.v_rgb565, 0);
    check_eq("midrst_field",  bus.v_field,  0);
    bus.v_ack = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (bus.v_stb) stale++;
      tick();
    end
    check_eq("midrst_stale", stale, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bt656cap_colorspace.md
BT656CAP_COLORSPACE -- requirements
Module: bt656cap_colorspace

Interface
REQ-001 SHALL have parameter fifo_depth, default 2, meaning log2 of the output FIFO entry count (4 entries).
REQ-002 SHALL have sys_clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have sys_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have p_stb  input  1  decoder word valid; free-running with no backpressure.
REQ-005 SHALL have p_field  input  1  field bit of the current word.
REQ-006 SHALL have p_ycc  input  32  word {Cb[31:24], Y0[23:16], Cr[15:8], Y1[7:0]}.
REQ-007 SHALL have v_stb  output  1  output word valid (FIFO not empty).
REQ-008 SHALL have v_ack  input  1  consumer accepts the word; transfer occurs when v_stb & v_ack.
REQ-009 SHALL have v_field  output  1  field bit of the head word.
REQ-010 SHALL have v_rgb565  output  32  {pixel0 from Y0, pixel1 from Y1}, each RGB565.
REQ-011 SHALL have overflow  output  1  one-cycle pulse when a converted word is dropped.
REQ-012 SHALL have drop_count  output  16  dropped-word counter (see Configuration).
REQ-013 SHALL have drop_clr  input  1  clears drop_count.

Function
REQ-014 SHALL compute, per pixel with Ys=Y-16, Cbs=Cb-128 and Crs=Cr-128 as signed values: R=(298Ys+409Crs+128)>>>8, G=(298Ys-208Crs-100Cbs+128)>>>8, B=(298Ys+516Cbs+128)>>>8.
REQ-015 SHALL use signed intermediates of at least 19 bits so that no overflow occurs for any 8-bit input.
REQ-016 SHALL saturate each of R, G and B to 0..255, then truncate to R[7:3], G[7:2], B[7:3].
REQ-017 SHALL share Cb and Cr between both pixels of a word.
REQ-018 SHALL be a 3-stage non-stalling pipeline: multiply, sum/round, saturate/pack. It accepts every p_stb cycle and propagates p_field alongside the data.
REQ-019 SHALL write the pipeline result into the FIFO 3 cycles after p_stb. If the FIFO was empty, v_stb rises on the cycle after that write.
REQ-020 SHALL make the FIFO first-word-fall-through: v_rgb565 and v_field are valid whenever v_stb=1 and are held stable until v_ack.
REQ-021 SHALL keep v_rgb565 and v_field unchanged while v_stb=0.
REQ-022 SHALL accept a write when the FIFO is full only if v_stb & v_ack occurs in the same cycle; occupancy is then unchanged.
REQ-023 SHALL otherwise drop the word when full, pulse overflow for exactly that cycle, and leave FIFO contents and order intact.
REQ-024 SHALL treat simultaneous read and write on a non-full FIFO as occupancy unchanged.
REQ-025 SHALL wrap FIFO read and write pointers modulo 2^fifo_depth.
REQ-026 SHALL ignore v_ack while v_stb=0.

Reset
REQ-027 SHALL, on sys_rst, clear all pipeline valid bits and empty the FIFO.
REQ-028 SHALL, on sys_rst, drive v_stb=0, overflow=0, v_rgb565=0, v_field=0 and drop_count=0.
REQ-029 SHALL discard words in flight when reset is asserted mid-operation; no word accepted before reset appears after it.
REQ-030 SHALL ignore p_stb during the reset cycle.

Configuration
REQ-031 SHALL, when BT656CAP_DROPCNT_EN is defined, increment drop_count on each overflow pulse, saturating at 16'hFFFF.
REQ-032 SHALL, when BT656CAP_DROPCNT_EN is defined, clear drop_count on drop_clr; if drop_clr and overflow coincide, drop_count becomes 1.
REQ-033 SHALL, when BT656CAP_DROPCNT_EN is undefined, tie drop_count to 0, ignore drop_clr, and keep the port list unchanged.

Verification
REQ-034 SHALL cover: p_ycc=32'h80EB80EB, v_ack=1 -> v_rgb565=32'hFFFF_FFFF, v_stb high 4 cycles after p_stb.
REQ-035 SHALL cover: p_ycc=32'h8010_8010 -> 32'h0000_0000; p_ycc={Cb=90,Y0=81,Cr=240,Y1=81} -> 32'hF800_F800.
REQ-036 SHALL cover: v_ack=0 with 5 consecutive p_stb -> 4 words stored, one overflow pulse, drop_count=1; then v_ack=1 -> the first 4 words delivered in order.
REQ-037 SHALL cover: FIFO full with v_ack=1 and a write in the same cycle -> no overflow, occupancy stays 4.
REQ-038 SHALL cover: sys_rst asserted with 2 words in the pipeline and 3 in the FIFO -> v_stb=0 next cycle, and no stale word after reset.
REQ-039 SHALL cover: p_field toggling 0->1 between words -> v_field follows each word exactly.
